keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 17 +
 rtl/keypad_fifo.sv | 46 ++++
 rtl/keypad_scanner.sv | 177 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;
  localparam int unsigned KP_ROWS       = 4;
  localparam int unsigned KP_COLS       = 4;
  localparam int unsigned KP_FIFO_DEPTH = 4;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  function automatic logic [1:0] lowest_row(input logic [KP_ROWS-1:0] rows);
    lowest_row = '0;
    for (int unsigned i = 0; i < KP_ROWS; i++) begin
      if (rows[KP_ROWS-1-i]) lowest_row = 2'(KP_ROWS-1-i);
    end
  endfunction
endpackage

// File: rtl/keypad_fifo.sv
// 4-entry key code FIFO; a push while full succeeds only alongside a pop.
module keypad_fifo
  import keypad_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  key_code_t data_i,
  input  logic      pop_i,
  output key_code_t data_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int unsigned PW = $clog2(KP_FIFO_DEPTH);

  key_code_t       mem_q [KP_FIFO_DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [PW:0]     cnt_q;
  logic            push_ok, pop_ok;

  assign full_o  = (cnt_q == (PW+1)'(KP_FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < KP_FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_ok) rd_q <= rd_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad reader with debounce and valid/ready output.
// Define KEYPAD_FIFO_EN to buffer up to four codes instead of one.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [KP_COLS-1:0] col_n,
  input  logic [KP_ROWS-1:0] row_n,
  output key_code_t          key_code,
  output logic               key_valid,
  input  logic               key_ready,
  output logic               overflow,
  input  logic               overflow_clr
);
  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_TICKS);

  logic [KP_ROWS-1:0] sync1_q, sync2_q, rows;
  logic [DW-1:0]      div_q;
  logic               tick;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [1:0]         col_q, col_d, row_q, row_d;
  logic               adv, emit, drop, ovf_q;
  key_code_t          emit_code;

  assign rows    = ~sync2_q;
  assign tick    = (div_q == DW'(SCAN_DIV - 1));
  assign cnt_inc = cnt_q + 1'b1;
  assign col_n   = ~(4'b0001 << col_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      state_q <= SCAN;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      sync1_q <= row_n;
      sync2_q <= sync1_q;
      div_q   <= tick ? '0 : div_q + 1'b1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    adv     = 1'b0;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (|rows) begin
            row_d = lowest_row(rows);
            if (DEBOUNCE_TICKS == 1) begin
              state_d = HELD;
              cnt_d   = '0;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = CW'(1);
            end
          end else begin
            adv = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (rows[row_q]) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              state_d = HELD;
              cnt_d   = '0;
            end
          end else begin
            state_d = SCAN;
            cnt_d   = '0;
            adv     = 1'b1;
          end
        end
        HELD: begin
          // Only the latched row is watched; other keys cannot prolong the hold.
          if (!rows[row_q]) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              state_d = SCAN;
              cnt_d   = '0;
              adv     = 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
    col_d = adv ? col_q + 1'b1 : col_q;
  end

  always_comb begin
    emit      = 1'b0;
    emit_code = {row_q, col_q};
    if (tick) begin
      if (state_q == SCAN && (|rows) && DEBOUNCE_TICKS == 1) begin
        emit      = 1'b1;
        emit_code = {lowest_row(rows), col_q};
      end else if (state_q == DEBOUNCE && rows[row_q] && cnt_inc == DB_MAX) begin
        emit = 1'b1;
      end
    end
  end

`ifdef KEYPAD_FIFO_EN
  logic fifo_full, fifo_empty, pop;

  assign pop       = key_ready && !fifo_empty;
  assign drop      = emit && fifo_full && !pop;
  assign key_valid = !fifo_empty;

  keypad_fifo u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (emit && !drop),
    .data_i (emit_code),
    .pop_i  (pop),
    .data_o (key_code),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );
`else
  key_code_t code_q, code_d;
  logic      valid_q, valid_d, accept, load;

  assign accept    = valid_q && key_ready;
  assign load      = emit && (!valid_q || accept);
  assign drop      = emit && !load;
  assign key_valid = valid_q;
  assign key_code  = code_q;

  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    if (load) begin
      code_d  = emit_code;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= drop | (ovf_q & ~overflow_clr);
  end
  assign overflow = ovf_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_n, row_n, key_code;
  logic       key_valid, key_ready = 1'b0, overflow, overflow_clr = 1'b0;
  logic [15:0] keys = '0;
  logic       force_low = 1'b1;
  int         checks = 0, failures = 0;
  bit         ok;

  always #5 clk = ~clk;

  // Key at row r, column c shorts row r low while column c is driven low.
  always_comb begin
    row_n = '1;
    if (force_low) row_n = '0;
    else begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end
  end

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the edge on which column c becomes active.
  task automatic wait_col(input int c, output bit found);
    logic [3:0] target;
    target = ~(4'b0001 << c);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (col_n != target) break;
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (col_n == target) begin found = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (key_valid) begin found = 1'b1; break; end
    end
  endtask

  task automatic press(input int code, input int hold, input int rel);
    wait_col(code % 4, ok);
    chk("col_seen", {7'd0, ok}, 8'd1);
    @(negedge clk) keys[code] = 1'b1;
    cycles(hold);
    @(negedge clk) keys = '0;
    cycles(rel);
  endtask

  task automatic pulse_ready();
    @(negedge clk) key_ready = 1'b1;
    @(posedge clk); #1;
    key_ready = 1'b0;
  endtask

  initial begin
    // Reset with every row pulled low.
    cycles(3);
    chk("rst_col_n", {4'd0, col_n}, 8'h0E);
    chk("rst_valid", {7'd0, key_valid}, 8'd0);
    chk("rst_ovf", {7'd0, overflow}, 8'd0);
    chk("rst_code", {4'd0, key_code}, 8'h00);
    @(negedge clk) rst = 1'b0;
    repeat (11) @(posedge clk); #1;
    chk("pre_emit_valid", {7'd0, key_valid}, 8'd0);
    chk("hold_col_n", {4'd0, col_n}, 8'h0E);
    cycles(1);
    chk("first_emit_valid", {7'd0, key_valid}, 8'd1);
    chk("first_emit_code", {4'd0, key_code}, 8'h00);
    cycles(40);
    chk("first_once_ovf", {7'd0, overflow}, 8'd0);
    @(negedge clk) force_low = 1'b0;
    cycles(40);
    pulse_ready();
    chk("first_accept", {7'd0, key_valid}, 8'd0);

    // Row 2 / col 1 held ~20 ticks.
    wait_col(1, ok);
    chk("col1_seen", {7'd0, ok}, 8'd1);
    @(negedge clk) keys[9] = 1'b1;
    wait_valid(ok);
    chk("k9_seen", {7'd0, ok}, 8'd1);
    chk("k9_code", {4'd0, key_code}, 8'h09);
    cycles(70);
    @(negedge clk) keys = '0;
    cycles(60);
    chk("k9_once_ovf", {7'd0, overflow}, 8'd0);
    chk("k9_keep_code", {4'd0, key_code}, 8'h09);
    pulse_ready();
    chk("k9_accept", {7'd0, key_valid}, 8'd0);

    // Row 1 / col 3 bounce of two ticks only.
    wait_col(3, ok);
    chk("col3_seen", {7'd0, ok}, 8'd1);
    @(negedge clk) keys[7] = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk) keys = '0;
    cycles(4);
    chk("bounce_col_adv", {4'd0, col_n}, 8'h0E);
    cycles(40);
    chk("bounce_no_emit", {7'd0, key_valid}, 8'd0);

    // Rows 1 and 3 together in col 2: lowest row wins.
    wait_col(2, ok);
    chk("col2_seen", {7'd0, ok}, 8'd1);
    @(negedge clk) begin keys[6] = 1'b1; keys[14] = 1'b1; end
    wait_valid(ok);
    chk("multi_seen", {7'd0, ok}, 8'd1);
    chk("multi_code", {4'd0, key_code}, 8'h06);
    cycles(40);
    @(negedge clk) keys = '0;
    cycles(60);
    chk("multi_once_ovf", {7'd0, overflow}, 8'd0);
    pulse_ready();
    chk("multi_accept", {7'd0, key_valid}, 8'd0);

    // Ready held high: valid is a single-cycle pulse.
    @(negedge clk) key_ready = 1'b1;
    wait_col(3, ok);
    chk("col3b_seen", {7'd0, ok}, 8'd1);
    @(negedge clk) keys[15] = 1'b1;
    wait_valid(ok);
    chk("kf_seen", {7'd0, ok}, 8'd1);
    chk("kf_code", {4'd0, key_code}, 8'h0F);
    cycles(1);
    chk("kf_consumed", {7'd0, key_valid}, 8'd0);
    @(negedge clk) keys = '0;
    cycles(60);
    @(negedge clk) key_ready = 1'b0;

`ifdef KEYPAD_FIFO_EN
    press(1, 40, 40);
    press(2, 40, 40);
    press(3, 40, 40);
    press(4, 40, 40);
    press(5, 40, 40);
    chk("fifo_ovf", {7'd0, overflow}, 8'd1);
    for (int k = 1; k <= 4; k++) begin
      chk("fifo_valid", {7'd0, key_valid}, 8'd1);
      chk("fifo_code", {4'd0, key_code}, 8'(k));
      pulse_ready();
    end
    chk("fifo_empty", {7'd0, key_valid}, 8'd0);
`else
    press(5, 40, 40);
    press(10, 40, 40);
    chk("drop_valid", {7'd0, key_valid}, 8'd1);
    chk("drop_code", {4'd0, key_code}, 8'h05);
    chk("drop_ovf", {7'd0, overflow}, 8'd1);
    pulse_ready();
`endif
    @(negedge clk) overflow_clr = 1'b1;
    @(posedge clk); #1;
    overflow_clr = 1'b0;
    chk("ovf_clr", {7'd0, overflow}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
